gpo_shift_engine: RTL and testbench
===================================

GPO_SHIFT_ENGINE -- requirements
Module: gpo_shift_engine

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, output pattern width in bits (>=1).
REQ-002 SHALL provide parameter RST_VAL, default 'h000F, GPO reset pattern, zero-extended or truncated to WIDTH.
REQ-003 SHALL provide parameter CNT_W, default 8, width of step counter.
REQ-004 SHALL provide port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL provide port GPI  input  WIDTH  parallel load data.
REQ-007 SHALL provide port load  input  1  parallel-load strobe.
REQ-008 SHALL provide port ready  input  1  step enable, one step per cycle while high.
REQ-009 SHALL provide port mode  input  2  step mode: 00 shift left, 01 shift right, 10 rotate left, 11 rotate right.
REQ-010 SHALL provide port fill  input  1  bit inserted at vacated position on shifts.
REQ-011 SHALL provide port GPO  output  WIDTH  registered pattern.
REQ-012 SHALL provide port shift_cnt  output  CNT_W  steps since last load or reset.
REQ-013 SHALL provide port empty  output  1  high when GPO is all zeros.

Function
REQ-014 SHALL give load priority over ready; load=1 at a rising edge sets GPO<=GPI and shift_cnt<=0 regardless of ready or mode.
REQ-015 SHALL, with load=0 and ready=1, update GPO by one step per mode, taking effect on the same edge (latency 1 cycle).
REQ-016 SHALL, for mode 00, set GPO<={GPO[WIDTH-2:0],fill}; for mode 01, GPO<={fill,GPO[WIDTH-1:1]}.
REQ-017 SHALL, for mode 10, set GPO<={GPO[WIDTH-2:0],GPO[WIDTH-1]}; for mode 11, GPO<={GPO[0],GPO[WIDTH-1:1]}; fill ignored.
REQ-018 SHALL, for WIDTH=1, load fill on shift modes and hold GPO on rotate modes.
REQ-019 SHALL hold GPO and shift_cnt when load=0 and ready=0.
REQ-020 SHALL sample mode and fill every cycle; a mode change between steps takes effect on the next step without flush.
REQ-021 SHALL increment shift_cnt by 1 on each step, saturating at all-ones (no wrap).
REQ-022 SHALL drive empty combinationally as (GPO==0), zero extra latency.

Reset
REQ-023 SHALL, while reset=1, asynchronously force GPO=RST_VAL and shift_cnt=0, independent of clk.
REQ-024 SHALL, on reset asserted mid-step, discard the step; first step after release acts on RST_VAL.
REQ-025 SHALL drive empty=(RST_VAL==0) during reset.

Configuration
REQ-026 SHALL, with macro GPO_SHIFT_ROTATE_EN defined, implement modes 10/11 as rotates per REQ-017.
REQ-027 SHALL, without GPO_SHIFT_ROTATE_EN, treat mode 10 as mode 00 and mode 11 as mode 01 (fill inserted), with no rotate logic synthesised.

Verification
REQ-028 SHALL check: reset pulse, defaults -> GPO=0x000F, shift_cnt=0, empty=0.
REQ-029 SHALL check: after reset, mode=00, fill=0, ready=1 for 4 cycles -> GPO=0x00F0, shift_cnt=4.
REQ-030 SHALL check: load GPI=0x8001, then mode=10, ready 1 cycle with macro -> GPO=0x0003; without macro -> GPO=0x0002.
REQ-031 SHALL check: load=1, ready=1, GPI=0x1234 same edge -> GPO=0x1234, shift_cnt=0.
REQ-032 SHALL check: CNT_W=2, ready held 5 steps mode=01 fill=0 from 0x000F -> shift_cnt=3, GPO=0x0000, empty=1.
REQ-033 SHALL check: reset asserted between edges mid-sequence -> GPO=0x000F immediately, before next clk edge.

Source files
------------

// File: rtl/gpo_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : gpo_shift_engine
// Description : Registered general-purpose output pattern. The pattern can be
//               parallel-loaded, or stepped once per cycle (shift or rotate,
//               left or right). A saturating counter tracks the number of
//               steps taken since the last load or reset.
//               Optional feature macro: GPO_SHIFT_ROTATE_EN
//                 defined   -> modes 10/11 rotate left/right
//                 undefined -> modes 10/11 behave as shift left/right
// Revision    : 1.0 - initial release
// ============================================================================
module gpo_shift_engine #(
  parameter int          WIDTH   = 16,
  parameter logic [63:0] RST_VAL = 64'h000F,
  parameter int          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] GPI,
  input  logic             load,
  input  logic             ready,
  input  logic [1:0]       mode,
  input  logic             fill,
  output logic [WIDTH-1:0] GPO,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             empty
);

  // Reset pattern fitted to the output width (zero-extend or truncate).
  localparam logic [WIDTH-1:0] C_RST_VAL = WIDTH'(RST_VAL);
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] r_gpo;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_step;

  generate
    if (WIDTH == 1) begin : g_narrow
      // A single bit can only be replaced by fill (shift) or kept (rotate),
      // so the direction bit of mode has no effect at this width.
      logic w_unused;
      assign w_unused = ^mode;

      // Next pattern for a one-bit register.
      always_comb begin
        w_step = fill;
`ifdef GPO_SHIFT_ROTATE_EN
        if (mode[1]) begin
          w_step = r_gpo;
        end
`endif
      end
    end else begin : g_wide
      // Next pattern after one step in the currently selected mode.
      always_comb begin
        w_step = r_gpo;
        case (mode)
`ifdef GPO_SHIFT_ROTATE_EN
          2'b00: w_step = {r_gpo[WIDTH-2:0], fill};
          2'b01: w_step = {fill, r_gpo[WIDTH-1:1]};
          2'b10: w_step = {r_gpo[WIDTH-2:0], r_gpo[WIDTH-1]};
          2'b11: w_step = {r_gpo[0], r_gpo[WIDTH-1:1]};
`else
          2'b00, 2'b10: w_step = {r_gpo[WIDTH-2:0], fill};
          2'b01, 2'b11: w_step = {fill, r_gpo[WIDTH-1:1]};
`endif
        endcase
      end
    end
  endgenerate

  // Pattern and step counter: load wins over step, idle cycles hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gpo <= C_RST_VAL;
      r_cnt <= '0;
    end else if (load) begin
      r_gpo <= GPI;
      r_cnt <= '0;
    end else if (ready) begin
      r_gpo <= w_step;
      if (r_cnt != C_CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign GPO       = r_gpo;
  assign shift_cnt = r_cnt;
  assign empty     = (r_gpo == '0);

endmodule
`default_nettype wire

// File: tb/tb_gpo_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpo_shift_engine
// Description : Self-checking bench for gpo_shift_engine. Two instances share
//               the stimulus: one with an 8-bit counter, one with a 2-bit
//               counter to exercise saturation. Expected values come from an
//               arithmetic reference model of the pattern and an unbounded
//               step count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpo_shift_engine;

`ifdef GPO_SHIFT_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] GPI;
  logic        load;
  logic        ready;
  logic [1:0]  mode;
  logic        fill;
  logic [15:0] GPO;
  logic [7:0]  shift_cnt;
  logic        empty;
  logic [15:0] GPO2;
  logic [1:0]  shift_cnt2;
  logic        empty2;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [15:0] m_gpo;
  int          m_cnt;

  always #5 clk = ~clk;

  gpo_shift_engine #(.WIDTH(16), .RST_VAL(64'h000F), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .GPI(GPI), .load(load), .ready(ready),
    .mode(mode), .fill(fill), .GPO(GPO), .shift_cnt(shift_cnt), .empty(empty)
  );

  gpo_shift_engine #(.WIDTH(16), .RST_VAL(64'h000F), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .GPI(GPI), .load(load), .ready(ready),
    .mode(mode), .fill(fill), .GPO(GPO2), .shift_cnt(shift_cnt2), .empty(empty2)
  );

  // One step of the pattern, expressed as integer arithmetic on the value.
  function automatic logic [15:0] ref_step(logic [15:0] g, logic [1:0] md, logic f);
    int  v;
    int  inb;
    bit  rot;
    v   = int'(g);
    rot = md[1] && ROT_EN;
    if (md[0] == 1'b0) begin
      inb = rot ? (v / 32768) : int'(f);
      v   = (v * 2) % 65536 + inb;
    end else begin
      inb = rot ? (v % 2) : int'(f);
      v   = v / 2 + inb * 32768;
    end
    return 16'(v);
  endfunction

  function automatic int sat(int c, int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  // Advance one rising edge and update the model with the applied inputs.
  task automatic tick();
    @(posedge clk);
    if (load) begin
      m_gpo = GPI;
      m_cnt = 0;
    end else if (ready) begin
      m_gpo = ref_step(m_gpo, mode, fill);
      m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; ready = 1'b0; mode = 2'b00; fill = 1'b0; GPI = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (GPO !== 16'h000F) begin failures++; $display("FAIL reset_gpo: got %h expected 000f", GPO); end
    checks++; if (shift_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", shift_cnt); end
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL reset_empty: got %b expected 0", empty); end
    @(negedge clk);
    reset = 1'b0;
    m_gpo = 16'h000F;
    m_cnt = 0;
  endtask

  task automatic test_shift_left();
    @(negedge clk);
    mode = 2'b00; fill = 1'b0; ready = 1'b1; load = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    ready = 1'b0;
    checks++; if (GPO !== 16'h00F0) begin failures++; $display("FAIL shl4_gpo: got %h expected 00f0", GPO); end
    checks++; if (shift_cnt !== 8'd4) begin failures++; $display("FAIL shl4_cnt: got %0d expected 4", shift_cnt); end
  endtask

  task automatic test_rotate();
    logic [15:0] exp_v;
    exp_v = ROT_EN ? 16'h0003 : 16'h0002;
    @(negedge clk);
    load = 1'b1; GPI = 16'h8001; ready = 1'b0;
    tick();
    @(negedge clk);
    load = 1'b0; mode = 2'b10; fill = 1'b0; ready = 1'b1;
    tick();
    @(negedge clk);
    ready = 1'b0;
    checks++; if (GPO !== exp_v) begin failures++; $display("FAIL rotl_gpo: got %h expected %h", GPO, exp_v); end
    checks++; if (shift_cnt !== 8'd1) begin failures++; $display("FAIL rotl_cnt: got %0d expected 1", shift_cnt); end
  endtask

  task automatic test_load_priority();
    @(negedge clk);
    load = 1'b1; ready = 1'b1; GPI = 16'h1234; mode = 2'($urandom_range(0, 3)); fill = 1'b1;
    tick();
    @(negedge clk);
    load = 1'b0; ready = 1'b0;
    checks++; if (GPO !== 16'h1234) begin failures++; $display("FAIL load_prio_gpo: got %h expected 1234", GPO); end
    checks++; if (shift_cnt !== 8'd0) begin failures++; $display("FAIL load_prio_cnt: got %0d expected 0", shift_cnt); end
    checks++; if (shift_cnt2 !== 2'd0) begin failures++; $display("FAIL load_prio_cnt2: got %0d expected 0", shift_cnt2); end
  endtask

  task automatic test_hold();
    logic [15:0] held;
    held = GPO;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      load = 1'b0; ready = 1'b0;
      mode = 2'($urandom_range(0, 3)); fill = 1'($urandom_range(0, 1)); GPI = 16'($urandom);
      tick();
      checks++; if (GPO !== held) begin failures++; $display("FAIL hold_gpo step %0d: got %h expected %h", i, GPO, held); end
      checks++; if (shift_cnt !== 8'd0) begin failures++; $display("FAIL hold_cnt step %0d: got %0d expected 0", i, shift_cnt); end
    end
  endtask

  task automatic test_saturation();
    // Fresh reset pulse, then five right shifts with zero fill.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_gpo = 16'h000F; m_cnt = 0;
    mode = 2'b01; fill = 1'b0; ready = 1'b1; load = 1'b0;
    repeat (5) tick();
    checks++; if (shift_cnt2 !== 2'd3) begin failures++; $display("FAIL sat2_cnt: got %0d expected 3", shift_cnt2); end
    checks++; if (GPO2 !== 16'h0000) begin failures++; $display("FAIL sat2_gpo: got %h expected 0000", GPO2); end
    checks++; if (empty2 !== 1'b1) begin failures++; $display("FAIL sat2_empty: got %b expected 1", empty2); end
    checks++; if (shift_cnt !== 8'd5) begin failures++; $display("FAIL sat8_cnt5: got %0d expected 5", shift_cnt); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL sat_empty: got %b expected 1", empty); end
    // Keep stepping well past 255 steps; the 8-bit counter must stick.
    repeat (260) tick();
    @(negedge clk);
    ready = 1'b0;
    checks++; if (shift_cnt !== 8'd255) begin failures++; $display("FAIL sat8_cnt: got %0d expected 255", shift_cnt); end
    checks++; if (shift_cnt2 !== 2'd3) begin failures++; $display("FAIL sat2_hold: got %0d expected 3", shift_cnt2); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    load = 1'b1; GPI = 16'($urandom) | 16'h0100;
    tick();
    @(negedge clk);
    load = 1'b0; ready = 1'b1; mode = 2'($urandom_range(0, 3)); fill = 1'b1;
    repeat (3) tick();
    // Assert between edges, with a step pending for the next edge.
    #2;
    reset = 1'b1;
    #1;
    checks++; if (GPO !== 16'h000F) begin failures++; $display("FAIL async_rst_gpo: got %h expected 000f", GPO); end
    checks++; if (shift_cnt !== 8'd0) begin failures++; $display("FAIL async_rst_cnt: got %0d expected 0", shift_cnt); end
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL async_rst_empty: got %b expected 0", empty); end
    @(posedge clk);
    #1;
    checks++; if (GPO !== 16'h000F) begin failures++; $display("FAIL rst_hold_gpo: got %h expected 000f", GPO); end
    @(negedge clk);
    reset = 1'b0; mode = 2'b00; fill = 1'b1; ready = 1'b1;
    m_gpo = 16'h000F; m_cnt = 0;
    tick();
    @(negedge clk);
    ready = 1'b0;
    checks++; if (GPO !== 16'h001F) begin failures++; $display("FAIL post_rst_step_gpo: got %h expected 001f", GPO); end
    checks++; if (shift_cnt !== 8'd1) begin failures++; $display("FAIL post_rst_step_cnt: got %0d expected 1", shift_cnt); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      load  = ($urandom_range(0, 11) == 0);
      ready = ($urandom_range(0, 3) != 0);
      mode  = 2'($urandom_range(0, 3));
      fill  = 1'($urandom_range(0, 1));
      GPI   = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
      tick();
      checks++; if (GPO !== m_gpo) begin failures++; $display("FAIL rand_gpo cycle %0d: got %h expected %h", i, GPO, m_gpo); end
      checks++; if (GPO2 !== m_gpo) begin failures++; $display("FAIL rand_gpo2 cycle %0d: got %h expected %h", i, GPO2, m_gpo); end
      checks++; if (shift_cnt !== 8'(sat(m_cnt, 8))) begin failures++; $display("FAIL rand_cnt cycle %0d: got %0d expected %0d", i, shift_cnt, sat(m_cnt, 8)); end
      checks++; if (shift_cnt2 !== 2'(sat(m_cnt, 2))) begin failures++; $display("FAIL rand_cnt2 cycle %0d: got %0d expected %0d", i, shift_cnt2, sat(m_cnt, 2)); end
      checks++; if (empty !== (m_gpo == 16'h0000)) begin failures++; $display("FAIL rand_empty cycle %0d: got %b expected %b", i, empty, (m_gpo == 16'h0000)); end
    end
    @(negedge clk);
    load = 1'b0; ready = 1'b0;
  endtask

  initial begin
    m_gpo = 16'h000F;
    m_cnt = 0;
    test_reset();
    test_shift_left();
    test_rotate();
    test_load_priority();
    test_hold();
    test_saturation();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
